// File: rtl/risc_pkg.sv
// Shared types for the RISC unified-memory arbiter: FSM states, grant select and default widths.
package risc_pkg;

    localparam int unsigned RISC_AW = 32;
    localparam int unsigned RISC_DW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_sel_e;

    // Data side wins unless it also won the previous grant and fetch is waiting.
    function automatic gnt_sel_e pick_grant(input logic if_req, input logic dm_req,
                                            input logic last_dm);
        return (dm_req && (!if_req || !last_dm)) ? GNT_DM : GNT_IF;
    endfunction

endpackage

// File: rtl/risc_arb_timer.sv
// Busy-cycle counter for the memory arbiter; expire_c flags the TIMEOUT-th busy cycle.
module risc_arb_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q;

    assign expire_c = run_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i && !expire_c) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Fetch/data arbiter for one single-port unified memory, one access in flight at a time.
// Optional busy timeout enabled by defining RISC_MEM_ARB_TIMEOUT_EN.
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned AW      = RISC_AW,
    parameter int unsigned DW      = RISC_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    output logic            dm_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err
);

    localparam int unsigned BW = DW / 8;

    arb_state_e    state_q, state_d;
    logic          last_dm_q, last_dm_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;

    logic          busy_c;
    logic          expire_c;
    logic          done_c;
    logic [DW-1:0] resp_data_c;
    gnt_sel_e      gnt_c;

    assign busy_c      = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    assign gnt_c       = pick_grant(if_req, dm_req, last_dm_q);
    assign done_c      = busy_c && (mem_ack || expire_c);
    // A timed-out access returns zero instead of whatever is on the bus.
    assign resp_data_c = mem_ack ? mem_rdata : '0;

`ifdef RISC_MEM_ARB_TIMEOUT_EN
    logic err_q;

    risc_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .clear_i  (state_q == IDLE),
        .run_i    (busy_c),
        .expire_c (expire_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (busy_c && !mem_ack && expire_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;

    assign expire_c       = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = |32'(TIMEOUT);
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    mem_req_d = 1'b1;
                    last_dm_d = (gnt_c == GNT_DM);
                    if (gnt_c == GNT_DM) begin
                        state_d     = DM_BUSY;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                    end else begin
                        state_d     = IF_BUSY;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (done_c) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = resp_data_c;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = resp_data_c;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;

    // Hazard-unit stalls follow the raw request and the registered completion pulse.
    assign if_stall  = if_req && !if_valid_q;
    assign dm_stall  = dm_req && !dm_valid_q;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Self-checking bench for risc_mem_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level model.
module tb_risc_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 4;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_valid, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_valid, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [BW-1:0] dm_be;
    logic          mem_req, mem_we, mem_ack, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        int          exp_valid_cyc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One directed transaction from IDLE; cycle 0 is the cycle the request is presented.
    task automatic run_vec(input vec_t v);
        int  c;
        bit  seen;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1 chk1("vec_stall_c0", v.is_dm ? dm_stall : if_stall, 1'b1);
        c = 0; seen = 0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (v.is_dm ? dm_valid : if_valid) begin
                seen = 1;
                chkw("vec_valid_cycle", c, v.exp_valid_cyc);
                chkw("vec_rdata", v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
                chk1("vec_req_in_resp", mem_req, 1'b0);
                chk1("vec_stall_resp", v.is_dm ? dm_stall : if_stall, 1'b0);
                if_req = 1'b0; dm_req = 1'b0;
            end else begin
                chk1("vec_busy_req", mem_req, 1'b1);
                chkw("vec_busy_addr", mem_addr, v.addr);
                chk1("vec_busy_we", mem_we, v.we);
                chk1("vec_busy_stall", v.is_dm ? dm_stall : if_stall, 1'b1);
                chk1("vec_valid_early", if_valid | dm_valid, 1'b0);
                if (v.we) begin
                    chkw("vec_busy_wdata", mem_wdata, v.wdata);
                    chkw("vec_busy_be", 32'(mem_be), 32'(v.be));
                end
                if (c == v.waits + 1) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end
            end
        end
        if (!seen) chk1("vec_valid_seen", 1'b0, 1'b1);
        @(negedge clk);
        chk1("vec_idle_after", mem_req | if_valid | dm_valid, 1'b0);
    endtask

    // Random traffic; the model reasons per transaction (grant rule, ack->valid, data capture).
    task automatic random_phase(input int ncyc);
        int          side = 0, wait_left = 0, cur_exp, exp_val_side = 0;
        int          if_age = 0, dm_age = 0, max_age = 0;
        bit          m_last_dm = 0, exp_dm;
        logic [31:0] exp_if_rd = '0, m_dm_rd = '0, r, g_addr = '0;
        logic        g_we = 1'b0;
        logic        pv_if_req = 1'b0, pv_dm_req = 1'b0, pv_dm_we = 1'b0;
        logic [31:0] pv_if_addr = '0, pv_dm_addr = '0, pv_dm_wdata = '0;
        logic [3:0]  pv_dm_be = '0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            cur_exp = exp_val_side; exp_val_side = 0;
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk1("rnd_if_valid", if_valid, cur_exp == 1);
            chk1("rnd_dm_valid", dm_valid, cur_exp == 2);
            chk1("rnd_if_stall", if_stall, if_req && cur_exp != 1);
            chk1("rnd_dm_stall", dm_stall, dm_req && cur_exp != 2);
            if (cur_exp == 1) chkw("rnd_if_rdata", if_rdata, exp_if_rd);
            if (cur_exp == 2) chkw("rnd_dm_rdata", dm_rdata, m_dm_rd);
            if (cur_exp != 0) begin
                chk1("rnd_req_in_resp", mem_req, 1'b0);
            end else if (side == 0) begin
                if (mem_req) begin
                    exp_dm = pv_dm_req && (!pv_if_req || !m_last_dm);
                    g_addr = exp_dm ? pv_dm_addr : pv_if_addr;
                    g_we   = exp_dm && pv_dm_we;
                    chk1("rnd_grant_had_req", pv_if_req | pv_dm_req, 1'b1);
                    chkw("rnd_grant_addr", mem_addr, g_addr);
                    chk1("rnd_grant_we", mem_we, g_we);
                    if (g_we) begin
                        chkw("rnd_grant_wdata", mem_wdata, pv_dm_wdata);
                        chkw("rnd_grant_be", 32'(mem_be), 32'(pv_dm_be));
                    end
                    side      = exp_dm ? 2 : 1;
                    m_last_dm = exp_dm;
                    wait_left = int'($urandom_range(3, 0));
                end
            end else begin
                chk1("rnd_busy_req", mem_req, 1'b1);
                chkw("rnd_busy_addr", mem_addr, g_addr);
            end
            if (side != 0) begin
                if (wait_left == 0) begin
                    r = $urandom; mem_ack = 1'b1; mem_rdata = r; exp_val_side = side;
                    if (side == 1) exp_if_rd = r;
                    else if (!g_we) m_dm_rd = r;
                    side = 0;
                end else begin
                    wait_left--;
                end
            end
            if (cur_exp == 1) begin if_req = 1'b0; if_age = 0; end
            if (cur_exp == 2) begin dm_req = 1'b0; dm_age = 0; end
            if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req = 1'b1; if_addr = {16'h0000, 16'($urandom) & 16'hFFFC};
            end
            if (!dm_req && $urandom_range(2, 0) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(1, 0));
                dm_addr = {16'h8000, 16'($urandom) & 16'hFFFC};
                dm_wdata = $urandom; dm_be = 4'($urandom_range(15, 1));
            end
            if (if_req) if_age++;
            if (dm_req) dm_age++;
            if (if_age > max_age) max_age = if_age;
            if (dm_age > max_age) max_age = dm_age;
            pv_if_req = if_req; pv_if_addr = if_addr;
            pv_dm_req = dm_req; pv_dm_addr = dm_addr; pv_dm_we = dm_we;
            pv_dm_wdata = dm_wdata; pv_dm_be = dm_be;
        end
        chk1("rnd_no_starvation", max_age <= 20, 1'b1);
        chk1("rnd_err_clear", err, 1'b0);
    endtask

    initial begin
        int good;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 32'h0050_0093, 2, 32'h0050_0093};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 32'h1234_5678, 3, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 3, 32'hFFFF_0000, 5, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 4, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF, 0, 32'hA5A5_5A5A, 2, 32'hA5A5_5A5A};

        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_be = '0; mem_rdata = '0;
        @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chkw("rst_mem_addr", mem_addr, 32'h0);
        chkw("rst_mem_wdata", mem_wdata, 32'h0);
        chkw("rst_mem_be", 32'(mem_be), 32'h0);
        chkw("rst_if_rdata", if_rdata, 32'h0);
        chkw("rst_dm_rdata", dm_rdata, 32'h0);
        chk1("rst_valids", if_valid | dm_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Tie handling: data first after reset, then the immediate repeat tie goes to fetch.
        do_reset();
        if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        @(negedge clk);
        chkw("tie1_addr", mem_addr, 32'h100);
        chk1("tie1_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("tie1_dm_valid", dm_valid, 1'b1);
        chk1("tie1_if_valid", if_valid, 1'b0);
        chkw("tie1_dm_rdata", dm_rdata, 32'h0BAD_F00D);
        chk1("tie1_if_stall", if_stall, 1'b1);
        dm_req = 1'b0;
        @(negedge clk);
        chk1("tie_idle_req", mem_req, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h104;
        @(negedge clk);
        chkw("tie2_addr", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("tie2_if_valid", if_valid, 1'b1);
        chk1("tie2_dm_valid", dm_valid, 1'b0);
        chkw("tie2_if_rdata", if_rdata, 32'h0000_0013);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chkw("tie3_addr", mem_addr, 32'h104);
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("tie3_dm_valid", dm_valid, 1'b1);
        chkw("tie3_dm_rdata", dm_rdata, 32'h5555_AAAA);
        dm_req = 1'b0;
        @(negedge clk);

`ifdef RISC_MEM_ARB_TIMEOUT_EN
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk1("to_busy_req", mem_req, 1'b1);
            chk1("to_no_valid", if_valid, 1'b0);
        end
        @(negedge clk);
        chk1("to_req_drop", mem_req, 1'b0);
        chk1("to_if_valid", if_valid, 1'b1);
        chkw("to_if_rdata", if_rdata, 32'h0);
        chk1("to_err_set", err, 1'b1);
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk1("to_err_sticky", err, 1'b1);
        chk1("to_valid_gone", if_valid, 1'b0);
        do_reset();
        chk1("to_err_reset", err, 1'b0);
`else
        if_req = 1'b1; if_addr = 32'h40;
        good = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (mem_req && !if_valid && !err) good++;
        end
        chkw("hang_cycles", good, 1000);
        do_reset();
`endif

        // Reset in the middle of a data access; an ack after reset must be ignored.
        run_vec(vecs[4]);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        @(negedge clk);
        chk1("mid_busy_req", mem_req, 1'b1);
        @(negedge clk);
        rst = 1'b0; dm_req = 1'b0;
        #1;
        chk1("mid_rst_req", mem_req, 1'b0);
        chkw("mid_rst_addr", mem_addr, 32'h0);
        chkw("mid_rst_dm_rdata", dm_rdata, 32'h0);
        chk1("mid_rst_valid", dm_valid | if_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("late_ack_dm_valid", dm_valid, 1'b0);
        chk1("late_ack_if_valid", if_valid, 1'b0);
        chk1("late_ack_req", mem_req, 1'b0);
        chkw("late_ack_dm_rdata", dm_rdata, 32'h0);

        do_reset();
        random_phase(800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
